qei_decoder_v2: RTL and testbench

//  Parametrised quadrature encoder interface, successor to the first-generation decoder.

---
 rtl/qei_decoder_v2.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_qei_decoder_v2.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/qei_decoder_v2.sv
// Quadrature encoder interface: synchronises and filters the A/B phases,
// decodes x1/x2/x4 steps, tracks wrapped shaft position, per-window signed
// counts and signed output-shaft RPM from a sequential restoring divider.
//
// Divider FSM states
//   state | meaning
//   IDLE  | waiting for a completed window (win_valid)
//   LOAD  | capture |win_count|*60*SAMPLE_HZ and the sign
//   DIV   | one restoring quotient bit per cycle, W cycles
//   DONE  | publish signed quotient on rpm, strobe rpm_valid
module qei_decoder_v2 #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int SAMPLE_HZ   = 10,
    parameter int CPR         = 12,
    parameter int GEAR_RATIO  = 1000,
    parameter int DECODE_MODE = 2,
    parameter int FILTER_LEN  = 3,
    parameter int POS_INIT    = 0,
    parameter int W           = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         chA,
    input  logic         chB,
    input  logic         position_rst,
    output logic [W-1:0] position,
    output logic         dir,
    output logic [W-1:0] win_count,
    output logic         win_valid,
    output logic [W-1:0] rpm,
    output logic         rpm_valid,
    output logic         err_pulse,
    output logic [15:0]  err_count
);

    localparam int WINDOW  = CLK_FREQ_HZ / SAMPLE_HZ;
    localparam int MULT    = (DECODE_MODE == 0) ? 1 : (DECODE_MODE == 1) ? 2 : 4;
    localparam int POS_MAX = CPR * MULT * GEAR_RATIO;
    localparam int TW      = $clog2(WINDOW);
    localparam int IW      = $clog2(W) + 1;

    localparam logic [TW-1:0]    T_LAST     = TW'(WINDOW - 1);
    localparam logic [3:0]       FLT_LAST   = 4'(FILTER_LEN - 1);
    localparam logic [W-1:0]     ZERO_W     = '0;
    localparam logic [W-1:0]     ONE_W      = W'(1);
    localparam logic [W-1:0]     POS_LAST   = W'(POS_MAX - 1);
    localparam logic [W-1:0]     POS_INIT_W = W'(POS_INIT);
    localparam logic [W-1:0]     DEN        = W'(POS_MAX);
    localparam logic [W:0]       DEN_EXT    = {1'b0, DEN};
    localparam logic [2*W-1:0]   RATE       = (2*W)'(60 * SAMPLE_HZ);
    localparam logic [IW-1:0]    IT_LAST    = IW'(W - 1);
    localparam logic [IW-1:0]    IT_ONE     = IW'(1);
    localparam logic [15:0]      ERR_MAX    = 16'hFFFF;
    localparam logic signed [W:0] STEP_UP   = (W+1)'(1);
    localparam logic signed [W:0] STEP_DN   = '1;
    localparam logic signed [W:0] SAT_HI    = {2'b00, {(W-1){1'b1}}};
    localparam logic signed [W:0] SAT_LO    = {2'b11, {(W-2){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, LOAD, DIV, DONE} div_state_t;

    // ---------------- input synchroniser and glitch filter ----------------
    logic       a_s1_q, a_s2_q, b_s1_q, b_s2_q;
    logic       a_filt_q, a_filt_d, b_filt_q, b_filt_d;
    logic [3:0] a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
    logic       a_prev_q, b_prev_q;

    // A level is accepted only after FILTER_LEN consecutive differing samples
    always_comb begin
        a_filt_d = a_filt_q;
        a_cnt_d  = '0;
        b_filt_d = b_filt_q;
        b_cnt_d  = '0;
        if (a_s2_q != a_filt_q) begin
            if (a_cnt_q == FLT_LAST) a_filt_d = a_s2_q;
            else                     a_cnt_d  = a_cnt_q + 4'd1;
        end
        if (b_s2_q != b_filt_q) begin
            if (b_cnt_q == FLT_LAST) b_filt_d = b_s2_q;
            else                     b_cnt_d  = b_cnt_q + 4'd1;
        end
    end

    // Two-flop synchronisers, filter state and previous filtered phase
    always_ff @(posedge clk) begin
        if (rst) begin
            a_s1_q   <= 1'b0;
            a_s2_q   <= 1'b0;
            b_s1_q   <= 1'b0;
            b_s2_q   <= 1'b0;
            a_filt_q <= 1'b0;
            b_filt_q <= 1'b0;
            a_cnt_q  <= '0;
            b_cnt_q  <= '0;
            a_prev_q <= 1'b0;
            b_prev_q <= 1'b0;
        end else begin
            a_s1_q   <= chA;
            a_s2_q   <= a_s1_q;
            b_s1_q   <= chB;
            b_s2_q   <= b_s1_q;
            a_filt_q <= a_filt_d;
            b_filt_q <= b_filt_d;
            a_cnt_q  <= a_cnt_d;
            b_cnt_q  <= b_cnt_d;
            a_prev_q <= a_filt_q;
            b_prev_q <= b_filt_q;
        end
    end

    // ---------------- phase decode ----------------
    logic a_chg, b_chg, illegal, step_en, step_up;

    // Forward is 00->10->11->01->00; direction follows from which bit moved
    always_comb begin
        a_chg   = a_filt_q ^ a_prev_q;
        b_chg   = b_filt_q ^ b_prev_q;
        illegal = a_chg & b_chg;
        step_en = 1'b0;
        step_up = 1'b0;
        if (DECODE_MODE == 0) begin
            step_en = a_chg & ~b_chg & a_filt_q;
            step_up = ~b_filt_q;
        end else if (DECODE_MODE == 1) begin
            step_en = a_chg & ~b_chg;
            step_up = a_filt_q ^ b_filt_q;
        end else begin
            step_en = a_chg ^ b_chg;
            step_up = a_chg ? (a_filt_q ^ b_filt_q) : ~(a_filt_q ^ b_filt_q);
        end
    end

    // ---------------- position, direction, error tracking ----------------
    logic [W-1:0] pos_q, pos_d;
    logic         dir_q, dir_d;
    logic         err_pulse_q, err_pulse_d;
    logic [15:0]  err_cnt_q, err_cnt_d;

    // position_rst beats a coincident step; errors count and saturate
    always_comb begin
        pos_d       = pos_q;
        dir_d       = dir_q;
        err_pulse_d = illegal;
        err_cnt_d   = err_cnt_q;
        if (position_rst) begin
            pos_d = POS_INIT_W;
        end else if (step_en) begin
            dir_d = step_up;
            if (step_up) pos_d = (pos_q == POS_LAST) ? ZERO_W : pos_q + ONE_W;
            else         pos_d = (pos_q == ZERO_W)   ? POS_LAST : pos_q - ONE_W;
        end
        if (illegal && (err_cnt_q != ERR_MAX)) err_cnt_d = err_cnt_q + 16'd1;
    end

    // Position and error registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pos_q       <= POS_INIT_W;
            dir_q       <= 1'b1;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            pos_q       <= pos_d;
            dir_q       <= dir_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    // ---------------- velocity window ----------------
    logic [TW-1:0]       timer_q, timer_d;
    logic signed [W-1:0] acc_q, acc_d, acc_sat;
    logic [W-1:0]        win_count_q, win_count_d;
    logic                win_valid_q, win_valid_d;
    logic signed [W:0]   step_ext, sum_ext;

    // Saturating accumulate; the closing cycle's own step lands in win_count
    always_comb begin
        step_ext = '0;
        if (step_en) step_ext = step_up ? STEP_UP : STEP_DN;
        sum_ext = $signed({acc_q[W-1], acc_q}) + step_ext;
        if (sum_ext > SAT_HI)      acc_sat = SAT_HI[W-1:0];
        else if (sum_ext < SAT_LO) acc_sat = SAT_LO[W-1:0];
        else                       acc_sat = sum_ext[W-1:0];
        timer_d     = timer_q + TW'(1);
        acc_d       = acc_sat;
        win_count_d = win_count_q;
        win_valid_d = 1'b0;
        if (timer_q == T_LAST) begin
            timer_d     = '0;
            acc_d       = '0;
            win_count_d = acc_sat;
            win_valid_d = 1'b1;
        end
    end

    // Window timer and accumulator registers
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q     <= '0;
            acc_q       <= '0;
            win_count_q <= '0;
            win_valid_q <= 1'b0;
        end else begin
            timer_q     <= timer_d;
            acc_q       <= acc_d;
            win_count_q <= win_count_d;
            win_valid_q <= win_valid_d;
        end
    end

    // ---------------- RPM divider ----------------
    div_state_t    state_q, state_d;
    logic [W-1:0]  rem_q, rem_d, quo_q, quo_d;
    logic [IW-1:0] it_q, it_d;
    logic          neg_q, neg_d;
    logic [W-1:0]  rpm_q, rpm_d;
    logic          rpm_valid_q, rpm_valid_d;
    logic [W-1:0]  mag;
    logic [2*W-1:0] num;
    logic [W:0]    trial, diff;
    logic          ge;

    // The quotient is assumed to fit in W bits, so the high dividend half
    // seeds the remainder and only the low half is shifted through.
    always_comb begin
        mag   = win_count_q[W-1] ? (ZERO_W - win_count_q) : win_count_q;
        num   = {ZERO_W, mag} * RATE;
        trial = {rem_q, quo_q[W-1]};
        diff  = trial - DEN_EXT;
        ge    = (trial >= DEN_EXT);
        state_d     = state_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        it_d        = it_q;
        neg_d       = neg_q;
        rpm_d       = rpm_q;
        rpm_valid_d = 1'b0;
        case (state_q)
            IDLE: if (win_valid_q) state_d = LOAD;
            LOAD: begin
                neg_d   = win_count_q[W-1];
                rem_d   = num[2*W-1:W];
                quo_d   = num[W-1:0];
                it_d    = '0;
                state_d = DIV;
            end
            DIV: begin
                rem_d = ge ? diff[W-1:0] : trial[W-1:0];
                quo_d = {quo_q[W-2:0], ge};
                it_d  = it_q + IT_ONE;
                if (it_q == IT_LAST) state_d = DONE;
            end
            DONE: begin
                rpm_d       = neg_q ? (ZERO_W - quo_q) : quo_q;
                rpm_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Divider state and datapath registers; reset aborts any division
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            quo_q       <= '0;
            it_q        <= '0;
            neg_q       <= 1'b0;
            rpm_q       <= '0;
            rpm_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            it_q        <= it_d;
            neg_q       <= neg_d;
            rpm_q       <= rpm_d;
            rpm_valid_q <= rpm_valid_d;
        end
    end

    assign position  = pos_q;
    assign dir       = dir_q;
    assign win_count = win_count_q;
    assign win_valid = win_valid_q;
    assign rpm       = rpm_q;
    assign rpm_valid = rpm_valid_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_cnt_q;

endmodule

// File: tb/tb_qei_decoder_v2.sv
// Directed bench for qei_decoder_v2: x4, x2 and x1 instances share the same
// encoder stimulus; WINDOW=100 cycles, CPR=12, GEAR_RATIO=1, FILTER_LEN=2.
module tb_qei_decoder_v2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic chA = 1'b0;
    logic chB = 1'b0;
    logic position_rst = 1'b0;

    logic [31:0] pos4, pos2, pos1, win4, win2, win1, rpm4, rpm2, rpm1;
    logic        dir4, dir2, dir1, wv4, wv2, wv1, rv4, rv2, rv1, ep4, ep2, ep1;
    logic [15:0] ec4, ec2, ec1;

    int passed = 0;
    int total  = 0;
    int err_seen4 = 0;

    always #5 clk = ~clk;

    always @(negedge clk) if (ep4 === 1'b1) err_seen4 <= err_seen4 + 1;

    qei_decoder_v2 #(.CLK_FREQ_HZ(1000), .SAMPLE_HZ(10), .CPR(12), .GEAR_RATIO(1),
                     .DECODE_MODE(2), .FILTER_LEN(2), .POS_INIT(0), .W(32)) dut4 (
        .clk(clk), .rst(rst), .chA(chA), .chB(chB), .position_rst(position_rst),
        .position(pos4), .dir(dir4), .win_count(win4), .win_valid(wv4),
        .rpm(rpm4), .rpm_valid(rv4), .err_pulse(ep4), .err_count(ec4));

    qei_decoder_v2 #(.CLK_FREQ_HZ(1000), .SAMPLE_HZ(10), .CPR(12), .GEAR_RATIO(1),
                     .DECODE_MODE(1), .FILTER_LEN(2), .POS_INIT(0), .W(32)) dut2 (
        .clk(clk), .rst(rst), .chA(chA), .chB(chB), .position_rst(position_rst),
        .position(pos2), .dir(dir2), .win_count(win2), .win_valid(wv2),
        .rpm(rpm2), .rpm_valid(rv2), .err_pulse(ep2), .err_count(ec2));

    qei_decoder_v2 #(.CLK_FREQ_HZ(1000), .SAMPLE_HZ(10), .CPR(12), .GEAR_RATIO(1),
                     .DECODE_MODE(0), .FILTER_LEN(2), .POS_INIT(0), .W(32)) dut1 (
        .clk(clk), .rst(rst), .chA(chA), .chB(chB), .position_rst(position_rst),
        .position(pos1), .dir(dir1), .win_count(win1), .win_valid(wv1),
        .rpm(rpm1), .rpm_valid(rv1), .err_pulse(ep1), .err_count(ec1));

    task automatic do_reset();
        rst = 1'b1;
        chA = 1'b0;
        chB = 1'b0;
        position_rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    // One quadrature edge, then hold for two clocks
    task automatic step(input bit fwd);
        logic [1:0] cur, nxt;
        cur = {chA, chB};
        if (fwd) begin
            case (cur)
                2'b00: nxt = 2'b10;
                2'b10: nxt = 2'b11;
                2'b11: nxt = 2'b01;
                default: nxt = 2'b00;
            endcase
        end else begin
            case (cur)
                2'b00: nxt = 2'b01;
                2'b01: nxt = 2'b11;
                2'b11: nxt = 2'b10;
                default: nxt = 2'b00;
            endcase
        end
        chA = nxt[1];
        chB = nxt[0];
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_win(input int max_cyc, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge clk);
            if (wv4 === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic wait_rpm(input int max_cyc, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge clk);
            if (rv4 === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (pos4 !== 32'd0) $display("FAIL reset_position got=%0d want=0", pos4); else passed++;
        total++; if (dir4 !== 1'b1) $display("FAIL reset_dir got=%0b want=1", dir4); else passed++;
        total++; if (win4 !== 32'd0) $display("FAIL reset_win_count got=%0d want=0", win4); else passed++;
        total++; if (rpm4 !== 32'd0) $display("FAIL reset_rpm got=%0d want=0", rpm4); else passed++;
        total++; if (ec4 !== 16'd0) $display("FAIL reset_err_count got=%0d want=0", ec4); else passed++;
        total++; if ({wv4, rv4, ep4} !== 3'b000) $display("FAIL reset_strobes got=%b want=000", {wv4, rv4, ep4}); else passed++;
    endtask

    task automatic test_forward_window();
        bit seen;
        do_reset();
        repeat (40) step(1'b1);
        wait_win(120, seen);
        total++; if (seen !== 1'b1) $display("FAIL fwd_win_valid_timeout got=0 want=1"); else passed++;
        total++; if (pos4 !== 32'd40) $display("FAIL fwd_x4_position got=%0d want=40", pos4); else passed++;
        total++; if (pos2 !== 32'd20) $display("FAIL fwd_x2_position got=%0d want=20", pos2); else passed++;
        total++; if (pos1 !== 32'd10) $display("FAIL fwd_x1_position got=%0d want=10", pos1); else passed++;
        total++; if (dir4 !== 1'b1) $display("FAIL fwd_x4_dir got=%0b want=1", dir4); else passed++;
        total++; if ($signed(win4) !== 40) $display("FAIL fwd_x4_win_count got=%0d want=40", $signed(win4)); else passed++;
        total++; if ($signed(win2) !== 20) $display("FAIL fwd_x2_win_count got=%0d want=20", $signed(win2)); else passed++;
        total++; if ($signed(win1) !== 10) $display("FAIL fwd_x1_win_count got=%0d want=10", $signed(win1)); else passed++;
        wait_rpm(60, seen);
        total++; if (seen !== 1'b1) $display("FAIL fwd_rpm_valid_timeout got=0 want=1"); else passed++;
        total++; if ($signed(rpm4) !== 500) $display("FAIL fwd_x4_rpm got=%0d want=500", $signed(rpm4)); else passed++;
        total++; if ($signed(rpm2) !== 500) $display("FAIL fwd_x2_rpm got=%0d want=500", $signed(rpm2)); else passed++;
        total++; if ($signed(rpm1) !== 500) $display("FAIL fwd_x1_rpm got=%0d want=500", $signed(rpm1)); else passed++;
    endtask

    task automatic test_wrap();
        do_reset();
        step(1'b0);
        repeat (6) @(negedge clk);
        total++; if (pos4 !== 32'd47) $display("FAIL wrap_rev_x4_position got=%0d want=47", pos4); else passed++;
        total++; if (dir4 !== 1'b0) $display("FAIL wrap_rev_x4_dir got=%0b want=0", dir4); else passed++;
        total++; if (pos2 !== 32'd0) $display("FAIL wrap_rev_x2_b_edge got=%0d want=0", pos2); else passed++;
        step(1'b1);
        repeat (47) step(1'b1);
        repeat (6) @(negedge clk);
        total++; if (pos4 !== 32'd47) $display("FAIL wrap_47_x4_position got=%0d want=47", pos4); else passed++;
        total++; if (pos2 !== 32'd0) $display("FAIL wrap_x2_position got=%0d want=0", pos2); else passed++;
        total++; if (pos1 !== 32'd0) $display("FAIL wrap_x1_position got=%0d want=0", pos1); else passed++;
        step(1'b1);
        repeat (6) @(negedge clk);
        total++; if (pos4 !== 32'd0) $display("FAIL wrap_48_x4_position got=%0d want=0", pos4); else passed++;
        total++; if (dir4 !== 1'b1) $display("FAIL wrap_48_x4_dir got=%0b want=1", dir4); else passed++;
    endtask

    task automatic test_glitch_and_error();
        int e0;
        do_reset();
        e0 = err_seen4;
        chA = 1'b1;
        @(negedge clk);
        chA = 1'b0;
        repeat (10) @(negedge clk);
        total++; if (pos4 !== 32'd0) $display("FAIL glitch_position got=%0d want=0", pos4); else passed++;
        total++; if (ec4 !== 16'd0) $display("FAIL glitch_err_count got=%0d want=0", ec4); else passed++;
        total++; if (err_seen4 - e0 !== 0) $display("FAIL glitch_err_pulses got=%0d want=0", err_seen4 - e0); else passed++;
        chA = 1'b1;
        chB = 1'b1;
        repeat (8) @(negedge clk);
        total++; if (err_seen4 - e0 !== 1) $display("FAIL illegal_err_pulses got=%0d want=1", err_seen4 - e0); else passed++;
        total++; if (ec4 !== 16'd1) $display("FAIL illegal_x4_err_count got=%0d want=1", ec4); else passed++;
        total++; if (ec1 !== 16'd1) $display("FAIL illegal_x1_err_count got=%0d want=1", ec1); else passed++;
        total++; if (pos4 !== 32'd0) $display("FAIL illegal_x4_position got=%0d want=0", pos4); else passed++;
        total++; if (pos2 !== 32'd0) $display("FAIL illegal_x2_position got=%0d want=0", pos2); else passed++;
        chA = 1'b0;
        chB = 1'b0;
        repeat (8) @(negedge clk);
        total++; if (ec4 !== 16'd2) $display("FAIL illegal_back_err_count got=%0d want=2", ec4); else passed++;
    endtask

    task automatic test_position_rst();
        bit seen;
        do_reset();
        step(1'b1);
        step(1'b1);
        repeat (4) @(negedge clk);
        total++; if (pos4 !== 32'd2) $display("FAIL prst_pre_x4_position got=%0d want=2", pos4); else passed++;
        total++; if (pos2 !== 32'd1) $display("FAIL prst_pre_x2_position got=%0d want=1", pos2); else passed++;
        // 11->01: the resulting step reaches the position register 5 edges later
        chA = 1'b0;
        repeat (4) @(negedge clk);
        position_rst = 1'b1;
        @(negedge clk);
        position_rst = 1'b0;
        total++; if (pos4 !== 32'd0) $display("FAIL prst_x4_position got=%0d want=0", pos4); else passed++;
        total++; if (pos2 !== 32'd0) $display("FAIL prst_x2_position got=%0d want=0", pos2); else passed++;
        total++; if (pos1 !== 32'd0) $display("FAIL prst_x1_position got=%0d want=0", pos1); else passed++;
        step(1'b1);
        repeat (6) @(negedge clk);
        total++; if (pos4 !== 32'd1) $display("FAIL prst_post_x4_position got=%0d want=1", pos4); else passed++;
        wait_win(120, seen);
        total++; if (seen !== 1'b1) $display("FAIL prst_win_valid_timeout got=0 want=1"); else passed++;
        total++; if ($signed(win4) !== 4) $display("FAIL prst_x4_win_count got=%0d want=4", $signed(win4)); else passed++;
        total++; if ($signed(win2) !== 2) $display("FAIL prst_x2_win_count got=%0d want=2", $signed(win2)); else passed++;
    endtask

    task automatic test_reverse_and_rst_mid_div();
        bit seen;
        int rv_count;
        do_reset();
        repeat (8) step(1'b0);
        wait_win(150, seen);
        total++; if (seen !== 1'b1) $display("FAIL rev_win_valid_timeout got=0 want=1"); else passed++;
        total++; if (pos4 !== 32'd40) $display("FAIL rev_x4_position got=%0d want=40", pos4); else passed++;
        total++; if ($signed(win4) !== -8) $display("FAIL rev_x4_win_count got=%0d want=-8", $signed(win4)); else passed++;
        total++; if ($signed(win2) !== -4) $display("FAIL rev_x2_win_count got=%0d want=-4", $signed(win2)); else passed++;
        total++; if ($signed(win1) !== -2) $display("FAIL rev_x1_win_count got=%0d want=-2", $signed(win1)); else passed++;
        wait_rpm(60, seen);
        total++; if (seen !== 1'b1) $display("FAIL rev_rpm_valid_timeout got=0 want=1"); else passed++;
        total++; if ($signed(rpm4) !== -100) $display("FAIL rev_x4_rpm got=%0d want=-100", $signed(rpm4)); else passed++;
        total++; if ($signed(rpm2) !== -100) $display("FAIL rev_x2_rpm got=%0d want=-100", $signed(rpm2)); else passed++;
        total++; if ($signed(rpm1) !== -100) $display("FAIL rev_x1_rpm got=%0d want=-100", $signed(rpm1)); else passed++;
        repeat (4) step(1'b1);
        wait_win(150, seen);
        total++; if (seen !== 1'b1) $display("FAIL middiv_win_valid_timeout got=0 want=1"); else passed++;
        total++; if ($signed(win4) !== 4) $display("FAIL middiv_x4_win_count got=%0d want=4", $signed(win4)); else passed++;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if (pos4 !== 32'd0) $display("FAIL middiv_position got=%0d want=0", pos4); else passed++;
        total++; if (win4 !== 32'd0) $display("FAIL middiv_win_count got=%0d want=0", win4); else passed++;
        total++; if (rpm4 !== 32'd0) $display("FAIL middiv_rpm got=%0d want=0", $signed(rpm4)); else passed++;
        total++; if ({wv4, rv4, ep4, dir4} !== 4'b0001) $display("FAIL middiv_strobes_dir got=%b want=0001", {wv4, rv4, ep4, dir4}); else passed++;
        rv_count = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (rv4 === 1'b1) rv_count++;
        end
        total++; if (rv_count !== 0) $display("FAIL middiv_no_rpm_valid got=%0d want=0", rv_count); else passed++;
        total++; if (rpm4 !== 32'd0) $display("FAIL middiv_rpm_held got=%0d want=0", $signed(rpm4)); else passed++;
    endtask

    initial begin
        test_reset();
        test_forward_window();
        test_wrap();
        test_glitch_and_error();
        test_position_rst();
        test_reverse_and_rst_mid_div();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got=expired want=finished");
        $fatal(1, "watchdog");
    end

endmodule
